// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: RV32I load/store unit driving a word-aligned, byte-enabled data-memory bus.
// Holds one transaction at a time and sequences it through IDLE, ACCESS and DONE.
module lsu_dmem_master #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_rdata,
    output logic [1:0]      o_fault,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [3:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t          state, state_nxt;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q, ld_val;
    logic [1:0]      fault_q, fault_in;
    logic            illegal, misaligned, accept, acc;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Request checks run on the raw inputs so the outcome is known at the accept edge.
    assign illegal    = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11) | (i_we & i_funct3[2]);
    assign misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) | ((i_funct3[1:0] == 2'b10) & |i_addr[1:0]);
    assign fault_in   = illegal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
    assign accept     = (state == IDLE) & i_req;
    assign acc        = (state == ACCESS);

    assign byte_sel = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
    assign ld_val   = (f3_q[1:0] == 2'b00) ? {{(XLEN-8){~f3_q[2] & byte_sel[7]}}, byte_sel} :
                      (f3_q[1:0] == 2'b01) ? {{(XLEN-16){~f3_q[2] & half_sel[15]}}, half_sel} :
                      i_mem_rdata;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_req ? ((|fault_in) ? DONE : ACCESS) : IDLE;
            ACCESS:  state_nxt = i_mem_ack ? DONE : ACCESS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= i_we;
                f3_q    <= i_funct3;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                fault_q <= fault_in;
            end
            if (acc && i_mem_ack && !we_q) rdata_q <= ld_val;
        end
    end

    always_comb begin
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_fault     = o_done ? fault_q : 2'b00;
        o_rdata     = rdata_q;
        o_mem_req   = acc;
        o_mem_we    = acc & we_q;
        o_mem_addr  = acc ? {addr_q[XLEN-1:2], 2'b00} : '0;
        o_mem_be    = !acc ? 4'b0000 :
                      (f3_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
                      (f3_q[1:0] == 2'b01) ? 4'b0011 << addr_q[1:0] : 4'b1111;
        o_mem_wdata = !(acc && we_q) ? '0 :
                      (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                      (f3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
    end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed and randomized accesses against an arithmetic reference model.
module tb_lsu_dmem_master;
    logic        i_clk = 1'b0, i_rstn = 1'b0, i_req = 1'b0, i_we = 1'b0, i_mem_ack = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0, i_wdata = '0, i_mem_rdata = '0;
    logic        o_busy, o_done, o_mem_req, o_mem_we;
    logic [1:0]  o_fault;
    logic [3:0]  o_mem_be;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    int          passes = 0, checks = 0;
    logic [31:0] exp_rdata = '0;

    lsu_dmem_master dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
        .o_fault(o_fault), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [1:0] model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b10;
        return (a % size_of(f3) != 0) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m = ((1 << size_of(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % size_of(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = size_of(f3);
        logic [31:0] v = rd >> (8 * (a % 4));
        if (sz == 4) return rd;
        v = v & ((32'd1 << (8 * sz)) - 1);
        if (!f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    // One full access: request, optional wait states, ack, done pulse, return to idle.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int dly, input logic [31:0] rd, input bit poke);
        logic [1:0] flt = model_fault(we, f3, a);
        @(negedge i_clk);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        @(negedge i_clk);
        i_req = 1'b0; i_we = $urandom; i_funct3 = $urandom; i_addr = $urandom; i_wdata = $urandom;
        if (flt != 2'b00) begin
            check("fault_done", {o_busy, o_done, o_mem_req}, 3'b110);
            check("fault_code", o_fault, flt);
        end else begin
            for (int w = 0; w <= dly; w++) begin
                if (w > 0) @(negedge i_clk);
                check("acc_req_done", {o_busy, o_done, o_mem_req, o_mem_we}, {3'b101, we});
                check("acc_addr", o_mem_addr, a & 32'hFFFF_FFFC);
                check("acc_be", o_mem_be, model_be(f3, a));
                check("acc_wdata", o_mem_wdata, we ? model_wdata(f3, wd) : 32'h0);
                i_req = poke && (w == 0);
                i_mem_ack = (w == dly);
                i_mem_rdata = (w == dly) ? rd : $urandom;
            end
            @(negedge i_clk);
            i_mem_ack = 1'b0; i_req = 1'b0; i_mem_rdata = $urandom;
            if (!we) exp_rdata = model_load(f3, a, rd);
            check("done_pulse", {o_busy, o_done, o_mem_req, o_fault}, 5'b11000);
        end
        check("done_rdata", o_rdata, exp_rdata);
        @(negedge i_clk);
        check("idle_after", {o_busy, o_done, o_mem_req, o_mem_be}, 7'b0);
        if (poke) begin
            @(negedge i_clk);
            check("no_retrigger", {o_busy, o_mem_req}, 2'b00);
        end
    endtask

    initial begin
        #2;
        check("reset_ctrl", {o_busy, o_done, o_fault, o_mem_req, o_mem_we, o_mem_be}, 10'b0);
        check("reset_data", o_rdata | o_mem_addr | o_mem_wdata, 32'h0);
        @(negedge i_clk); i_rstn = 1'b1;

        do_access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        check("lw_value", o_rdata, 32'hDEAD_BEEF);
        do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 3, 32'h80FF_0000, 1'b0);
        check("lb_value", o_rdata, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 3, 32'h80FF_0000, 1'b0);
        check("lbu_value", o_rdata, 32'h0000_0080);
        do_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 1, 32'h0, 1'b0);
        do_access(1'b1, 3'b000, 32'h0000_0201, 32'h1234_ABCD, 0, 32'h0, 1'b0);
        check("store_keeps_rdata", o_rdata, 32'h0000_0080);
        do_access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h5555_5555, 1'b0);
        do_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h5555_5555, 1'b0);
        do_access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h5555_5555, 1'b0);
        do_access(1'b0, 3'b101, 32'h0000_0106, 32'h0, 2, 32'h9ABC_0000, 1'b1);
        check("lhu_value", o_rdata, 32'h0000_9ABC);

        for (int n = 0; n < 60; n++)
            do_access($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));

        // Make sure the held load result is nonzero so the reset clear is observable.
        do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0300;
        @(negedge i_clk);
        i_req = 1'b0;
        check("pre_reset_access", {o_busy, o_mem_req}, 2'b11);
        #2 i_rstn = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check("midreset_ctrl", {o_busy, o_done, o_fault, o_mem_req, o_mem_we, o_mem_be}, 10'b0);
        check("midreset_rdata", o_rdata, 32'h0);
        check("midreset_bus", o_mem_addr | o_mem_wdata, 32'h0);
        @(negedge i_clk); i_rstn = 1'b1;
        @(negedge i_clk);
        check("no_retry", {o_busy, o_mem_req}, 2'b00);
        do_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1, 32'h0BAD_CAFE, 1'b0);
        check("post_reset_lw", o_rdata, 32'h0BAD_CAFE);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
